// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router source framer
package router_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REJECT,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_ERRCHK
  } state_t;

  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

  localparam int         MAX_LEN      = 63;
  localparam logic [1:0] ILLEGAL_ADDR = 2'd3;

  // A request is forwarded only if it targets a real port and carries payload.
  function automatic logic is_legal(input logic [1:0] addr, input logic [5:0] len);
    return (addr != ILLEGAL_ADDR) && (len != 6'd0);
  endfunction

endpackage

// File: rtl/router_src_buf.sv
// rtl/router_src_buf.sv - single-port payload buffer, synchronous write, registered read
module router_src_buf #(
  parameter int DATA_W = 8,
  parameter int AW     = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One shared address: written while loading, read (one byte ahead) while sending.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/router_src_framer.sv
// rtl/router_src_framer.sv - router source stage; optional ROUTER_SRC_PARITY_INJ_EN adds inject_err
module router_src_framer
  import router_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int LEN_W    = 6,
  parameter int ERR_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
`ifdef ROUTER_SRC_PARITY_INJ_EN
  input  logic              inject_err,
`endif
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic [DATA_W-1:0] pay_data,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_in,
  input  logic              busy,
  input  logic              error,
  output logic              done,
  output logic              done_err
);

  localparam int BUF_DEPTH = MAX_LEN + 1;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  ptr;
  logic [DATA_W-1:0] parity_q;
  logic [DATA_W-1:0] parity_out;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        err_cnt;
  logic              err_sticky;
  logic              advance;
  logic [LEN_W-1:0]  rd_addr;
  logic [LEN_W-1:0]  buf_addr;
  logic              buf_we;
  hdr_t              hdr;

  assign hdr = '{len: len_q, addr: addr_q};

`ifdef ROUTER_SRC_PARITY_INJ_EN
  logic inj_q;
  assign parity_out = inj_q ? ~parity_q : parity_q;
`else
  assign parity_out = parity_q;
`endif

  // The router takes a byte on every non-busy cycle once the header is out,
  // so the read pointer steps ahead to keep rd_data one byte in front.
  assign advance  = !busy && (((state == S_HEADER) && pkt_valid) ||
                              ((state == S_PAYLOAD) && (ptr != len_q)));
  assign rd_addr  = advance ? ptr + LEN_W'(1) : ptr;
  assign buf_addr = (state == S_LOAD) ? cnt : rd_addr;
  assign buf_we   = (state == S_LOAD) && pay_valid && pay_ready;

  router_src_buf #(
    .DATA_W (DATA_W),
    .AW     (LEN_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clock (clock),
    .we    (buf_we),
    .addr  (buf_addr),
    .wdata (pay_data),
    .rdata (rd_data)
  );

  // Packet FSM: request, load, header/payload/parity to the router, error window, status.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      pay_ready  <= 1'b0;
      pkt_valid  <= 1'b0;
      data_in    <= '0;
      done       <= 1'b0;
      done_err   <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
      ptr        <= '0;
      parity_q   <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
`ifdef ROUTER_SRC_PARITY_INJ_EN
      inj_q      <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr_q    <= req_addr;
            len_q     <= req_len;
            cnt       <= '0;
            ptr       <= '0;
            // Seeding with the header folds it into the running parity.
            parity_q  <= DATA_W'({req_len, req_addr});
`ifdef ROUTER_SRC_PARITY_INJ_EN
            inj_q     <= inject_err;
`endif
            if (!is_legal(req_addr, req_len)) begin
              if (req_len == '0) begin
                done     <= 1'b1;
                done_err <= 1'b1;
              end else begin
                pay_ready <= 1'b1;
                state     <= S_REJECT;
              end
            end else begin
              pay_ready <= 1'b1;
              state     <= S_LOAD;
            end
          end else begin
            // Held low through the done cycle, so a new request waits one cycle.
            req_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (pay_valid && pay_ready) begin
            parity_q <= parity_q ^ pay_data;
            cnt      <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              pay_ready <= 1'b0;
              state     <= S_HEADER;
            end
          end
        end
        S_REJECT: begin
          if (pay_valid && pay_ready) begin
            cnt <= cnt + LEN_W'(1);
            if (cnt == len_q - LEN_W'(1)) begin
              pay_ready <= 1'b0;
              done      <= 1'b1;
              done_err  <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_HEADER: begin
          // First cycle only primes the buffer read of byte 0; the header goes out next.
          if (!pkt_valid) begin
            pkt_valid <= 1'b1;
            data_in   <= DATA_W'(hdr);
          end else if (!busy) begin
            data_in <= rd_data;
            ptr     <= ptr + LEN_W'(1);
            state   <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            if (ptr == len_q) begin
              data_in   <= parity_out;
              pkt_valid <= 1'b0;
              state     <= S_PARITY;
            end else begin
              data_in <= rd_data;
              ptr     <= ptr + LEN_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            data_in    <= '0;
            err_cnt    <= '0;
            err_sticky <= 1'b0;
            state      <= S_ERRCHK;
          end
        end
        S_ERRCHK: begin
          err_sticky <= err_sticky | error;
          err_cnt    <= err_cnt + 4'd1;
          if (err_cnt == 4'(ERR_WAIT - 1)) begin
            done     <= 1'b1;
            done_err <= err_sticky | error;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
